cnn_ram_loader: RTL and testbench
=================================

# cnn_ram_loader

Front-end loader for the CNN buffer memory. It accepts one stream of signed samples over a valid/ready handshake. The first picture_size*picture_size samples are written as pixels into the picture memory at a programmable base address. The following samples are packed nine at a time into 3x3 weight words and written into the weight memory. It drives the pixel and weight write ports of the CNN RAM directly and signals completion to the layer sequencer.

## Interface
- picture_size, 28, image side length in pixels.
- SIZE_1, 11, width of one sample (pixel or coefficient).
- SIZE_9, 99, width of one weight word; always 9*SIZE_1.
- SIZE_address_pix, 13, pixel write address width.
- SIZE_address_wei, 9, weight write address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request; honoured only in IDLE.
- base_addr_p  in  SIZE_address_pix  first pixel address; sampled on accepted start.
- n_wwords  in  SIZE_address_wei  number of weight words to load (0 = none); sampled on accepted start.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a beat this cycle.
- in_data  in  SIZE_1  signed pixel or coefficient.
- we_p  out  1  pixel write strobe.
- write_addressp  out  SIZE_address_pix  pixel write address.
- dp  out  SIZE_1  pixel write data.
- we_w  out  1  weight write strobe.
- write_addressw  out  SIZE_address_wei  weight write address.
- dw  out  SIZE_9  packed weight word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD_PIX, LOAD_WEI, DONE.
- IDLE: on start, latch base_addr_p and n_wwords, clear the counters, and go to LOAD_PIX.
- A beat is accepted when in_valid && in_ready.
- in_ready = 1 in LOAD_PIX and LOAD_WEI; 0 in IDLE and DONE.
- LOAD_PIX, per accepted beat k (k = 0..P*P-1, P = picture_size):
  - register dp = in_data, write_addressp = base + k (modulo 2^SIZE_address_pix), we_p = 1.
  - After beat P*P-1 is accepted: go to LOAD_WEI, or to DONE if n_wwords = 0.
- LOAD_WEI, per accepted beat:
  - Shift the coefficient into the pack register. Coefficient 0 of a word occupies dw[SIZE_9-1 -: SIZE_1]; coefficient 8 occupies dw[SIZE_1-1:0].
  - After the 9th coefficient, register dw and write_addressw = word index (0-based) and pulse we_w.
  - After the last coefficient of word n_wwords-1: go to DONE.
- DONE: lasts exactly one cycle with done = 1, then returns to IDLE. The final write strobe coincides with this cycle.
- start in any non-IDLE state, including DONE, is ignored.
- in_valid with in_ready low: no beat is accepted and there is no side effect.
- Reset, including mid-load: state IDLE and all counters 0; the partial pack register is discarded. Outputs: we_p = we_w = in_ready = busy = done = 0, dp = 0, dw = 0, write_addressp = 0, write_addressw = 0.

## Timing
- A beat accepted at cycle t produces we_p at t+1, or we_w at t+1 if it was the 9th coefficient.
- Strobes are high for exactly one cycle per write.
- Address and data outputs hold their last value when the strobe is low.
- No bubble between phases: in_ready stays high from the first pixel through the last coefficient, so the peak rate is one beat per cycle.
- The last beat accepted at t gives DONE (done = 1, final strobe) at t+1, and IDLE with busy = 0 at t+2.
- A start accepted at t gives busy = 1 and in_ready = 1 at t+1.
- Counters: the pixel counter needs ceil(log2(P*P)) bits, the coefficient counter is 4 bits (0..8), and the weight word counter is SIZE_address_wei bits.

## Structure
- The shared CNN package holds:
  - state encoding (2-bit enum IDLE/LOAD_PIX/LOAD_WEI/DONE);
  - the taps-per-kernel constant 9;
  - the derived widths SIZE_9 = 9*SIZE_1 and the pixel count P*P.
- One sub-module, cnn_weight_packer: a 9-deep SIZE_1 shift/pack register with a beat-in input, a 4-bit count, a word_valid pulse and a clear input.
- The FSM, pixel address generation and output registers live in the top module.

## Test plan
Run with picture_size = 4, SIZE_1 = 11.
- Pixels only: start with base = 100 and n_wwords = 0, then 16 back-to-back beats with values 1..16.
  - Required: we_p on 16 consecutive cycles, addresses 100..115, dp = 1..16.
  - done on the cycle of the 16th write; busy falls the cycle after.
- One weight word: n_wwords = 1, 16 pixels then coefficients 1..9, with coefficient 9 = -1.
  - Required: one we_w at address 0.
  - dw[98:88] = 1, dw[10:0] = 11'h7FF.
  - done coincides with we_w.
- Backpressure on in_valid: n_wwords = 2, in_valid toggled 1010….
  - Required: writes only for accepted beats.
  - Weight words land at addresses 0 and 1, with data identical to the no-gap run.
- Address wrap: base = 8190 with SIZE_address_pix = 13.
  - Required: pixel addresses 8190, 8191, 0, 1, … 13.
- Start while busy: pulse start at pixel beat 5 and again in the DONE cycle.
  - Required: no restart, no extra writes; the sequence is identical to the single-start run.
- Reset mid-load: assert rst after 7 pixels and 4 coefficients.
  - Required: all outputs 0 immediately (asynchronous).
  - A new start then writes from coefficient slot 0, with no stale coefficients in dw.

Source files
------------

// File: rtl/cnn_ram_loader_pkg.sv
// Shared CNN definitions: loader state encoding, kernel tap count and derived widths.
package cnn_ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_PIX = 2'd1,
    LOAD_WEI = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int TAPS = 9;

  function automatic int size9(input int size_1);
    return TAPS * size_1;
  endfunction

  function automatic int pix_count(input int picture_size);
    return picture_size * picture_size;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_weight_packer.sv
// Packs nine consecutive coefficients into one 3x3 weight word, first coefficient in the MSBs.
module cnn_weight_packer
  import cnn_ram_loader_pkg::*;
#(
  parameter int SIZE_1 = 11,
  localparam int SIZE_9 = TAPS * SIZE_1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_beat,
  input  logic [SIZE_1-1:0] i_data,
  output logic              o_word_valid,
  output logic [SIZE_9-1:0] o_word
);

  // Only eight coefficients are stored; the ninth completes the word straight from the input.
  logic [SIZE_9-SIZE_1-1:0] r_pack;
  logic [3:0]               r_count;
  logic                     w_last;

  assign w_last       = (r_count == 4'(TAPS - 1));
  assign o_word_valid = i_beat && w_last;
  assign o_word       = {r_pack, i_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_pack  <= '0;
      r_count <= '0;
    end else if (i_beat) begin
      r_pack  <= {r_pack[SIZE_9-2*SIZE_1-1:0], i_data};
      r_count <= w_last ? 4'd0 : r_count + 4'd1;
    end
  end

endmodule

// File: rtl/cnn_ram_loader.sv
// Streams pixels then packed 3x3 weight words into the CNN RAM write ports.
module cnn_ram_loader
  import cnn_ram_loader_pkg::*;
#(
  parameter int picture_size     = 28,
  parameter int SIZE_1           = 11,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 9,
  localparam int SIZE_9          = TAPS * SIZE_1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SIZE_address_pix-1:0] base_addr_p,
  input  logic [SIZE_address_wei-1:0] n_wwords,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [SIZE_1-1:0]    in_data,
  output logic                        we_p,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic signed [SIZE_1-1:0]    dp,
  output logic                        we_w,
  output logic [SIZE_address_wei-1:0] write_addressw,
  output logic [SIZE_9-1:0]           dw,
  output logic                        busy,
  output logic                        done
);

  localparam int NPIX  = pix_count(picture_size);
  localparam int PIX_W = cnt_width(NPIX);

  state_t                      r_state;
  logic [SIZE_address_pix-1:0] r_base;
  logic [SIZE_address_wei-1:0] r_nw;
  logic [PIX_W-1:0]            r_pix_cnt;
  logic [SIZE_address_wei-1:0] r_wword_cnt;
  logic                        r_in_ready, r_busy, r_done, r_we_p, r_we_w;
  logic signed [SIZE_1-1:0]    r_dp;
  logic [SIZE_9-1:0]           r_dw;
  logic [SIZE_address_pix-1:0] r_addr_p;
  logic [SIZE_address_wei-1:0] r_addr_w;

  logic              w_accept, w_clear, w_beat_w, w_word_vld, w_last_pix, w_last_word;
  logic [SIZE_9-1:0] w_word;

  assign w_accept    = in_valid && r_in_ready;
  assign w_clear     = (r_state == IDLE) && start;
  assign w_beat_w    = w_accept && (r_state == LOAD_WEI);
  assign w_last_pix  = (r_pix_cnt == PIX_W'(NPIX - 1));
  assign w_last_word = (r_wword_cnt == r_nw - SIZE_address_wei'(1));

  cnn_weight_packer #(.SIZE_1(SIZE_1)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_beat       (w_beat_w),
    .i_data       (in_data),
    .o_word_valid (w_word_vld),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_nw        <= '0;
      r_pix_cnt   <= '0;
      r_wword_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we_p      <= 1'b0;
      r_we_w      <= 1'b0;
      r_dp        <= '0;
      r_dw        <= '0;
      r_addr_p    <= '0;
      r_addr_w    <= '0;
    end else begin
      r_we_p <= 1'b0;
      r_we_w <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base      <= base_addr_p;
            r_nw        <= n_wwords;
            r_pix_cnt   <= '0;
            r_wword_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= LOAD_PIX;
          end
        end
        LOAD_PIX: begin
          if (w_accept) begin
            r_we_p    <= 1'b1;
            r_dp      <= in_data;
            r_addr_p  <= r_base + SIZE_address_pix'(r_pix_cnt);
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            if (w_last_pix) begin
              if (r_nw == '0) begin
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= DONE;
              end else begin
                r_state <= LOAD_WEI;
              end
            end
          end
        end
        LOAD_WEI: begin
          if (w_word_vld) begin
            r_we_w      <= 1'b1;
            r_dw        <= w_word;
            r_addr_w    <= r_wword_cnt;
            r_wword_cnt <= r_wword_cnt + SIZE_address_wei'(1);
            if (w_last_word) begin
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign we_p           = r_we_p;
  assign we_w           = r_we_w;
  assign dp             = r_dp;
  assign dw             = r_dw;
  assign write_addressp = r_addr_p;
  assign write_addressw = r_addr_w;

endmodule

// File: tb/tb_cnn_ram_loader.sv
// Randomized bench for cnn_ram_loader with a transaction-level model of the expected RAM writes.
module tb_cnn_ram_loader;

  localparam int P    = 4;
  localparam int S1   = 11;
  localparam int AP   = 13;
  localparam int AW   = 9;
  localparam int S9   = 9 * S1;
  localparam int NPIX = P * P;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AP-1:0]        base_addr_p;
  logic [AW-1:0]        n_wwords;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [S1-1:0] in_data;
  logic                 we_p;
  logic [AP-1:0]        write_addressp;
  logic signed [S1-1:0] dp;
  logic                 we_w;
  logic [AW-1:0]        write_addressw;
  logic [S9-1:0]        dw;
  logic                 busy;
  logic                 done;

  cnn_ram_loader #(
    .picture_size     (P),
    .SIZE_1           (S1),
    .SIZE_address_pix (AP),
    .SIZE_address_wei (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr_p    (base_addr_p),
    .n_wwords       (n_wwords),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .we_p           (we_p),
    .write_addressp (write_addressp),
    .dp             (dp),
    .we_w           (we_w),
    .write_addressw (write_addressw),
    .dw             (dw),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic signed [S1-1:0] stim[$];
  logic [127:0]         obs_p[$];
  logic [127:0]         obs_w[$];
  int                   pix_cyc[$];
  int                   cyc = 0;
  int                   done_cnt = 0;
  logic                 done_strobe = 1'b0;
  logic                 busy_after = 1'b1;
  logic                 prev_done = 1'b0;
  int                   n_tests = 0;
  int                   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_p) begin
      obs_p.push_back((128'(write_addressp) << S1) | 128'($unsigned(dp)));
      pix_cyc.push_back(cyc);
    end
    if (we_w) obs_w.push_back((128'(write_addressw) << S9) | 128'(dw));
    if (done) begin
      done_cnt    <= done_cnt + 1;
      done_strobe <= we_p || we_w;
    end
    if (prev_done) busy_after <= busy;
    prev_done <= done;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic gen_stim(input int nw, input bit fixed);
    stim.delete();
    for (int k = 0; k < NPIX + 9 * nw; k++) begin
      if (!fixed)          stim.push_back(S1'($urandom));
      else if (k < NPIX)   stim.push_back(S1'(k + 1));
      else if ((k - NPIX) % 9 == 8) stim.push_back(-S1'(1));
      else                 stim.push_back(S1'((k - NPIX) % 9 + 1));
    end
  endtask

  task automatic do_start(input string tag, input int base, input int nw);
    @(posedge clk);
    #1 start = 1'b1; base_addr_p = AP'(base); n_wwords = AW'(nw);
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_start_busy"}, 128'(busy), 128'(1));
    check({tag, "_start_rdy"}, 128'(in_ready), 128'(1));
  endtask

  // mode 0: back-to-back, 1: valid toggling 1010..., 2: random gaps
  task automatic feed(input string tag, input int mode, input bit glitch, input int abort_after);
    int   idx = 0;
    int   cycles = 0;
    logic v, rdy;
    while (idx < stim.size() && cycles < 2000) begin
      v        = (mode == 1) ? (cycles % 2 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_data  = stim[idx];
      start    = glitch && (idx == 5);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      cycles++;
      #1;
      if (abort_after > 0 && idx == abort_after) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort_after == 0) begin
      check({tag, "_accepted"}, 128'(idx), 128'(stim.size()));
      start = glitch;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_model(input string tag, input int base, input int nw,
                             input int sp, input int sw, input int dc);
    logic [127:0] e, g;
    logic [S9-1:0] w;
    check({tag, "_npix"}, 128'(obs_p.size() - sp), 128'(NPIX));
    for (int k = 0; k < NPIX; k++) begin
      e = (128'((base + k) % (1 << AP)) << S1) | 128'($unsigned(stim[k]));
      g = (sp + k < obs_p.size()) ? obs_p[sp + k] : '1;
      check($sformatf("%s_pix%0d", tag, k), g, e);
    end
    check({tag, "_nwei"}, 128'(obs_w.size() - sw), 128'(nw));
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < 9; j++) w = (w << S1) | S9'($unsigned(stim[NPIX + 9 * i + j]));
      e = (128'(i) << S9) | 128'(w);
      g = (sw + i < obs_w.size()) ? obs_w[sw + i] : '1;
      check($sformatf("%s_wei%0d", tag, i), g, e);
    end
    check({tag, "_done_cnt"}, 128'(done_cnt - dc), 128'(1));
    check({tag, "_done_strobe"}, 128'(done_strobe), 128'(1));
    check({tag, "_busy_after"}, 128'(busy_after), 128'(0));
  endtask

  task automatic run(input string tag, input int base, input int nw, input int mode,
                     input bit glitch, output int sp, output int sw);
    int dc;
    sp = obs_p.size();
    sw = obs_w.size();
    dc = done_cnt;
    do_start(tag, base, nw);
    feed(tag, mode, glitch, 0);
    repeat (3) @(posedge clk);
    #1;
    check_model(tag, base, nw, sp, sw, dc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 128'({we_p, we_w, in_ready, busy, done, dp, write_addressp, write_addressw}), '0);
    check({tag, "_dw"}, 128'(dw), '0);
  endtask

  task automatic abort_run(input string tag, input int nw, input int after);
    gen_stim(nw, 1'b0);
    do_start(tag, 37, nw);
    feed(tag, 0, 1'b0, after);
    rst = 1'b1;
    #1 check_zero(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int sp, sw;
    rst = 1'b1; start = 1'b0; base_addr_p = '0; n_wwords = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    gen_stim(0, 1'b1);
    run("pix_only", 100, 0, 0, 1'b0, sp, sw);
    check("pix_only_consec", 128'(pix_cyc[sp + NPIX - 1] - pix_cyc[sp]), 128'(NPIX - 1));

    gen_stim(1, 1'b1);
    run("one_word", 0, 1, 0, 1'b0, sp, sw);
    check("one_word_c0", 128'(obs_w[sw][98:88]), 128'(1));
    check("one_word_c8", 128'(obs_w[sw][10:0]), 128'(11'h7FF));

    gen_stim(2, 1'b0);
    run("nogap", 500, 2, 0, 1'b0, sp, sw);
    run("gap", 500, 2, 1, 1'b0, sp, sw);

    gen_stim(0, 1'b0);
    run("wrap", 8190, 0, 0, 1'b0, sp, sw);
    check("wrap_third", 128'(obs_p[sp + 2] >> S1), 128'(0));

    gen_stim(1, 1'b0);
    run("restart", 50, 1, 0, 1'b1, sp, sw);

    abort_run("rst_pix", 2, 7);
    abort_run("rst_coef", 2, NPIX + 4);
    gen_stim(1, 1'b0);
    run("after_rst", 200, 1, 0, 1'b0, sp, sw);

    for (int r = 0; r < 4; r++) begin
      int b, n;
      b = $urandom_range(0, (1 << AP) - 1);
      n = $urandom_range(0, 3);
      gen_stim(n, 1'b0);
      run($sformatf("rand%0d", r), b, n, 2, 1'b0, sp, sw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
